// File: rtl/coin_anim_ctrl.sv
// Coin spin/collect animation sequencer with a two-stage sprite pixel fetch.
// Stage 1 registers the shared ROM address; stage 2 registers the selected colour.
module coin_anim_ctrl #(
  parameter int unsigned NUM_FRAMES    = 4,
  parameter int unsigned FRAME_DIV     = 8,
  parameter int unsigned SPRITE_W      = 20,
  parameter int unsigned SPRITE_H      = 20,
  parameter int unsigned COLLECT_TICKS = 24,
  parameter logic [11:0] TRANSPARENT   = 12'h808
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        coin_active,
  input  logic        collect,
  input  logic [9:0]  coin_x,
  input  logic [9:0]  coin_y,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [11:0] rom_color_0,
  input  logic [11:0] rom_color_1,
  input  logic [11:0] rom_color_2,
  input  logic [11:0] rom_color_3,
  output logic [8:0]  read_address,
  output logic [11:0] pixel_color,
  output logic        pixel_valid,
  output logic        coin_done
);

  localparam int unsigned DivW  = $clog2(FRAME_DIV);
  localparam int unsigned TickW = (COLLECT_TICKS > 1) ? $clog2(COLLECT_TICKS) : 1;

  localparam logic [DivW-1:0]  SpinWrap    = DivW'(FRAME_DIV - 1);
  localparam logic [DivW-1:0]  CollectWrap = DivW'(FRAME_DIV / 2 - 1);
  localparam logic [1:0]       LastFrame   = 2'(NUM_FRAMES - 1);
  localparam logic [TickW-1:0] LastTick    = TickW'(COLLECT_TICKS - 1);

  typedef enum logic [1:0] {StIdle, StSpin, StCollect, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        frame_q, frame_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [4:0]        y_off_q, y_off_d;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;

  logic [8:0]        read_address_q, read_address_d;
  logic              in_box_s1_q, in_box_d;
  logic [1:0]        frame_s1_q;
  logic [11:0]       pixel_color_q, pixel_color_d;
  logic              pixel_valid_q, pixel_valid_d;
  logic              coin_done_q, coin_done_d;

  // Divider/frame advance shared by SPIN and COLLECT; only the wrap point differs.
  logic [DivW-1:0] wrap_pt;
  logic [DivW-1:0] adv_div;
  logic [1:0]      adv_frame;

  always_comb begin
    wrap_pt   = (state_q == StCollect) ? CollectWrap : SpinWrap;
    adv_div   = div_q + 1'b1;
    adv_frame = frame_q;
    if (div_q == wrap_pt) begin
      adv_div   = '0;
      adv_frame = (frame_q == LastFrame) ? 2'd0 : frame_q + 2'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    div_d      = div_q;
    y_off_d    = y_off_q;
    tick_cnt_d = tick_cnt_q;
    if (!coin_active) begin
      state_d    = StIdle;
      frame_d    = '0;
      div_d      = '0;
      y_off_d    = '0;
      tick_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSpin;
          frame_d = '0;
          div_d   = '0;
        end
        StSpin: begin
          // A collect pulse swallows a coincident frame_tick.
          if (collect) begin
            state_d    = StCollect;
            frame_d    = '0;
            div_d      = '0;
            y_off_d    = '0;
            tick_cnt_d = '0;
          end else if (frame_tick) begin
            div_d   = adv_div;
            frame_d = adv_frame;
          end
        end
        StCollect: begin
          if (frame_tick) begin
            div_d      = adv_div;
            frame_d    = adv_frame;
            y_off_d    = y_off_q + 5'd1;
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick_cnt_q == LastTick) begin
              state_d = StDone;
            end
          end
        end
        StDone: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Stage 1: bounding box and ROM address, all arithmetic at 11 bits.
  logic [10:0] x_ext, y_ext, cx_ext, cy_ext, y_top, col, row;
  logic        off_screen, visible;
  logic [8:0]  addr_calc;

  always_comb begin
    x_ext      = {1'b0, DrawX};
    y_ext      = {1'b0, DrawY};
    cx_ext     = {1'b0, coin_x};
    cy_ext     = {1'b0, coin_y};
    y_top      = cy_ext - {6'b0, y_off_q};
    off_screen = coin_y < {5'b0, y_off_q};
    visible    = (state_q == StSpin) || (state_q == StCollect);
    in_box_d   = visible && !off_screen &&
                 (x_ext >= cx_ext) && (x_ext < cx_ext + 11'(SPRITE_W)) &&
                 (y_ext >= y_top) && (y_ext < y_top + 11'(SPRITE_H));
    col        = x_ext - cx_ext;
    row        = y_ext - y_top;
    addr_calc  = 9'(row * 11'(SPRITE_W) + col);
    read_address_d = in_box_d ? addr_calc : '0;
  end

  // Stage 2: colour chosen with the frame latched alongside the address.
  logic [11:0] sel_color;

  always_comb begin
    sel_color = rom_color_0;
    unique case (frame_s1_q)
      2'd0: sel_color = rom_color_0;
      2'd1: sel_color = rom_color_1;
      2'd2: sel_color = rom_color_2;
      2'd3: sel_color = rom_color_3;
    endcase
    pixel_valid_d = in_box_s1_q && (sel_color != TRANSPARENT);
    pixel_color_d = pixel_valid_d ? sel_color : 12'h000;
    coin_done_d   = (state_q == StDone);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= StIdle;
      frame_q        <= '0;
      div_q          <= '0;
      y_off_q        <= '0;
      tick_cnt_q     <= '0;
      read_address_q <= '0;
      in_box_s1_q    <= 1'b0;
      frame_s1_q     <= '0;
      pixel_color_q  <= '0;
      pixel_valid_q  <= 1'b0;
      coin_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      div_q          <= div_d;
      y_off_q        <= y_off_d;
      tick_cnt_q     <= tick_cnt_d;
      read_address_q <= read_address_d;
      in_box_s1_q    <= in_box_d;
      frame_s1_q     <= frame_q;
      pixel_color_q  <= pixel_color_d;
      pixel_valid_q  <= pixel_valid_d;
      coin_done_q    <= coin_done_d;
    end
  end

  assign read_address = read_address_q;
  assign pixel_color  = pixel_color_q;
  assign pixel_valid  = pixel_valid_q;
  assign coin_done    = coin_done_q;

endmodule

// File: tb/tb_coin_anim_ctrl.sv
// Bench for coin_anim_ctrl: tick-count model checked every cycle plus directed literal checks.
module tb_coin_anim_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic        coin_active = 1'b0;
  logic        collect = 1'b0;
  logic [9:0]  coin_x = '0;
  logic [9:0]  coin_y = '0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [11:0] rom_color_0, rom_color_1, rom_color_2, rom_color_3;
  logic [8:0]  read_address;
  logic [11:0] pixel_color;
  logic        pixel_valid;
  logic        coin_done;

  logic        transp_en = 1'b0;
  logic [8:0]  transp_addr = '0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  // Sprite ROM stand-in: frame number in the top bits, bit 9 set so only the
  // override can ever produce the transparent colour.
  function automatic logic [11:0] rom_f(input int k, input logic [8:0] a, input logic en,
                                        input logic [8:0] ta);
    logic [1:0] kb;
    kb = 2'(k);
    if (en && a == ta) return 12'h808;
    return {kb, 1'b1, a};
  endfunction

  assign rom_color_0 = rom_f(0, read_address, transp_en, transp_addr);
  assign rom_color_1 = rom_f(1, read_address, transp_en, transp_addr);
  assign rom_color_2 = rom_f(2, read_address, transp_en, transp_addr);
  assign rom_color_3 = rom_f(3, read_address, transp_en, transp_addr);

  coin_anim_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_tick   (frame_tick),
    .coin_active  (coin_active),
    .collect      (collect),
    .coin_x       (coin_x),
    .coin_y       (coin_y),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .rom_color_0  (rom_color_0),
    .rom_color_1  (rom_color_1),
    .rom_color_2  (rom_color_2),
    .rom_color_3  (rom_color_3),
    .read_address (read_address),
    .pixel_color  (pixel_color),
    .pixel_valid  (pixel_valid),
    .coin_done    (coin_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: phase 0 none, 1 spinning, 2 collecting, 3 finished; ticks counted per phase.
  int          m_phase = 0;
  int          m_ticks = 0;
  logic [8:0]  m_addr_s1 = '0;
  logic        m_inbox_s1 = 1'b0;
  int          m_frame_s1 = 0;
  logic [11:0] m_color = '0;
  logic        m_valid = 1'b0;
  logic        m_done = 1'b0;

  always @(posedge Clk or negedge Reset_n) begin : model
    int yoff, frm, top;
    logic [11:0] c;
    logic inb;
    if (!Reset_n) begin
      m_phase = 0; m_ticks = 0; m_addr_s1 = '0; m_inbox_s1 = 1'b0; m_frame_s1 = 0;
      m_color = '0; m_valid = 1'b0; m_done = 1'b0;
    end else begin
      c       = rom_f(m_frame_s1, m_addr_s1, transp_en, transp_addr);
      m_valid = m_inbox_s1 && (c != 12'h808);
      m_color = m_valid ? c : 12'h000;
      yoff = (m_phase == 2) ? m_ticks : 0;
      frm  = (m_phase == 1) ? (m_ticks / 8) % 4 : (m_phase == 2) ? (m_ticks / 4) % 4 : 0;
      top  = int'(coin_y) - yoff;
      inb  = (m_phase == 1 || m_phase == 2) && top >= 0 &&
             int'(DrawX) >= int'(coin_x) && int'(DrawX) < int'(coin_x) + 20 &&
             int'(DrawY) >= top && int'(DrawY) < top + 20;
      m_addr_s1  = inb ? 9'((int'(DrawY) - top) * 20 + int'(DrawX) - int'(coin_x)) : 9'd0;
      m_inbox_s1 = inb;
      m_frame_s1 = frm;
      m_done     = (m_phase == 3);
      if (!coin_active) begin
        m_phase = 0; m_ticks = 0;
      end else begin
        case (m_phase)
          0: begin m_phase = 1; m_ticks = 0; end
          1: if (collect) begin m_phase = 2; m_ticks = 0; end
             else if (frame_tick) m_ticks++;
          2: if (frame_tick) begin
               m_ticks++;
               if (m_ticks == 24) m_phase = 3;
             end
          default: ;
        endcase
      end
    end
  end

  always @(negedge Clk) begin
    chk("cyc_read_address", 32'(read_address), 32'(m_addr_s1));
    chk("cyc_pixel_color", 32'(pixel_color), 32'(m_color));
    chk("cyc_pixel_valid", 32'(pixel_valid), 32'(m_valid));
    chk("cyc_coin_done", 32'(coin_done), 32'(m_done));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      @(negedge Clk);
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_read_address", 32'(read_address), 32'd0);
    chk("rst_pixel_color", 32'(pixel_color), 32'd0);
    chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    chk("rst_coin_done", 32'(coin_done), 32'd0);
    Reset_n = 1'b1;
    cyc(1);

    coin_active = 1'b1; coin_x = 10'd100; coin_y = 10'd200; DrawX = 10'd105; DrawY = 10'd203;
    cyc(2);
    chk("first_addr", 32'(read_address), 32'd65);
    cyc(1);
    chk("first_color", 32'(pixel_color), 32'h241);
    chk("first_valid", 32'(pixel_valid), 32'd1);

    transp_en = 1'b1; transp_addr = 9'd65;
    cyc(1);
    chk("transp_valid", 32'(pixel_valid), 32'd0);
    chk("transp_color", 32'(pixel_color), 32'd0);
    DrawX = 10'd99;
    cyc(1);
    chk("left_edge_addr", 32'(read_address), 32'd0);
    DrawX = 10'd105; transp_en = 1'b0;
    cyc(2);

    tick(8);
    cyc(2);
    chk("spin_frame1", 32'(pixel_color), 32'h641);
    tick(24);
    cyc(2);
    chk("spin_wrap", 32'(pixel_color), 32'h241);

    collect = 1'b1; frame_tick = 1'b1;
    cyc(1);
    collect = 1'b0; frame_tick = 1'b0;
    cyc(1);
    tick(4);
    cyc(2);
    chk("collect4_addr", 32'(read_address), 32'd145);
    chk("collect4_color", 32'(pixel_color), 32'h691);
    tick(4);
    cyc(2);
    chk("collect8_color", 32'(pixel_color), 32'hAE1);

    coin_y = 10'd2;
    cyc(1);
    chk("offscreen_addr", 32'(read_address), 32'd0);
    cyc(1);
    chk("offscreen_valid", 32'(pixel_valid), 32'd0);
    coin_y = 10'd200;

    tick(15);
    chk("done_not_yet", 32'(coin_done), 32'd0);
    tick(1);
    chk("done_set", 32'(coin_done), 32'd1);
    cyc(2);
    chk("done_invisible", 32'(pixel_valid), 32'd0);
    coin_active = 1'b0;
    cyc(2);
    chk("done_clear", 32'(coin_done), 32'd0);

    coin_active = 1'b1;
    cyc(2);
    collect = 1'b1;
    cyc(1);
    collect = 1'b0;
    tick(10);
    cyc(2);
    chk("collect10_color", 32'(pixel_color), 32'hB09);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_addr", 32'(read_address), 32'd0);
    chk("async_color", 32'(pixel_color), 32'd0);
    chk("async_valid", 32'(pixel_valid), 32'd0);
    chk("async_done", 32'(coin_done), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    cyc(4);
    chk("post_rst_addr", 32'(read_address), 32'd65);
    chk("post_rst_color", 32'(pixel_color), 32'h241);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
